gray_sweep_ctrl: RTL
====================

# gray_sweep_ctrl

Sequencer that walks a binary index from a programmed start value to a programmed end value, up or down, with modulo wrap. Each step is converted to Gray code, and the binary/Gray pair is presented on a valid/ready output stream. It sits in front of the binary-to-Gray encoding datapath and drives it under control of a host (start/pause/abort). Downstream consumers are position encoders, async-FIFO pointer test harnesses and display sweeps.

## Interface
- WIDTH, 4, bit width of the binary index and the Gray output (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a sweep; sampled only in IDLE
- start_val  in  WIDTH  first binary index; latched on accepted start
- end_val  in  WIDTH  last binary index; latched on accepted start
- dir  in  1  0 = count up, 1 = count down; latched on accepted start
- pause  in  1  level; hold the sweep after the current word transfers
- abort  in  1  terminate the sweep; highest priority
- out_ready  in  1  consumer accepts the word
- out_valid  out  1  binary/gray word is valid
- binary  out  WIDTH  current binary index (registered)
- gray  out  WIDTH  binary ^ (binary >> 1) (registered, same cycle as binary)
- busy  out  1  high in EMIT and PAUSE
- done  out  1  one-cycle pulse after the last word transfers

## Operation
- FSM states: IDLE, EMIT, PAUSE, DONE.
- **Reset (async):** state IDLE; out_valid=0, binary=0, gray=0, busy=0, done=0.
- **IDLE:**
  - start=1 → latch start_val, end_val and dir.
  - Load binary=start_val and gray=enc(start_val).
  - Go to EMIT.
- **EMIT:** out_valid=1. A transfer occurs when out_valid & out_ready.
  - Transfer and binary==end_val → DONE.
  - Transfer, otherwise → binary steps ±1 mod 2^WIDTH (15→0 going up, 0→15 going down for WIDTH=4), and gray is updated in the same edge.
    - If pause=1 on that cycle, go to PAUSE.
    - Otherwise stay in EMIT.
  - No transfer → binary, gray and out_valid hold unchanged. pause has no effect until a transfer, so out_valid never drops without a transfer.
- **PAUSE:** out_valid=0, binary/gray hold the next word. pause=0 → EMIT.
- **DONE:** done=1 and busy=0 for one cycle, then IDLE. binary/gray hold the last word.
- **Abort:** in any non-IDLE state, abort=1 → IDLE at the next edge with out_valid=0. This is the only permitted drop of out_valid without a transfer. done is not pulsed; binary/gray hold.
- **Simultaneous events:**
  - abort beats transfer and pause.
  - start is ignored in every state except IDLE, including DONE.
- **Word count:** up = ((end_val − start_val) mod 2^WIDTH)+1; down = ((start_val − end_val) mod 2^WIDTH)+1. start_val==end_val gives exactly one word.

## Timing
- Start sampled at edge N → out_valid=1 with binary=start_val from cycle N+1.
- With out_ready held at 1: one word per cycle, no bubbles.
- Last transfer at edge K → done=1 in cycle K+1; IDLE in K+2; a new start is sampled at edge K+2 at the earliest.
- Pause asserted in a transfer cycle at edge K → out_valid=0 from K+1. Pause released at edge P → out_valid=1 from P+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package gray_ctrl_pkg:
  - state encoding localparams (IDLE=2'd0, EMIT=2'd1, PAUSE=2'd2, DONE=2'd3)
  - DIR_UP/DIR_DOWN constants
- Sub-module gray_encode (pure combinational, WIDTH-parameterised): computes the next gray from the next binary. Its output is registered in gray_sweep_ctrl.

## Test plan
- **Full sweep:** start_val=0, end_val=15, dir=0, out_ready=1, WIDTH=4 → 16 consecutive words, gray 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8; done pulses one cycle after word 8; busy low afterwards.
- **Wrap and down count:**
  - start_val=14, end_val=1, dir=0 → binary 14,15,0,1 / gray 9,8,0,1.
  - start_val=3, end_val=0, dir=1 → gray 2,3,1,0.
- **Backpressure:** out_ready=0 for 3 cycles while binary=5 → gray=7 and out_valid=1 held stable for all 3 cycles; the next word (6→gray 5) follows the transfer.
- **Pause:** pause=1 during the transfer of binary=2 → out_valid=0 with binary=3 held. Release → gray 2 (binary 3) emitted; the sweep completes and the word count is unchanged.
- **Abort and reset:**
  - abort mid-sweep → IDLE next cycle, out_valid=0, no done pulse.
  - rst asserted asynchronously mid-sweep → all outputs 0 immediately.
  - After either, a fresh start works normally.
- **Edge controls:**
  - start_val=end_val=9 → exactly one word (gray D), then done.
  - start pulsed while busy or in DONE → ignored, latched values unchanged.

Source files
------------

// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray-code sweep controller: FSM state
// encoding and the count-direction constants.
package gray_ctrl_pkg;

   // Sweep controller states; the encoding is fixed so waveforms and
   // debug taps read the same across revisions.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EMIT  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Count direction as sampled on the dir input.
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage : gray_ctrl_pkg

// File: rtl/gray_encode.sv
// Binary-to-Gray encoder, purely combinational. The caller registers
// the result so the Gray word always lines up with its binary source.
module gray_encode #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   // Each Gray bit is the XOR of the binary bit and its upper neighbour.
   always_comb begin
      gray = bin ^ (bin >> 1);
   end

endmodule : gray_encode

// File: rtl/gray_sweep_chk.sv
// Protocol checker for the sweep controller outputs. Holds only
// assertions; it drives nothing and has no effect on synthesis results.
module gray_sweep_chk #(
   parameter int WIDTH = 4
) (
   input logic             clk,
   input logic             rst,
   input logic             abort,
   input logic             out_ready,
   input logic             out_valid,
   input logic [WIDTH-1:0] binary,
   input logic [WIDTH-1:0] gray,
   input logic             busy,
   input logic             done
);

   // The Gray output must always be the encoding of the binary output.
   a_gray_matches : assert property (@(posedge clk) disable iff (rst)
      gray == (binary ^ (binary >> 1)));

   // A presented word stays put until it is taken or the sweep is aborted.
   a_valid_stable : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !abort) |=> (out_valid && $stable(binary)));

   // The completion flag is a single-cycle pulse.
   a_done_pulse : assert property (@(posedge clk) disable iff (rst)
      done |=> !done);

   // Completion is never reported while the sweep still counts as busy.
   a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
      !(busy && done));

   // Words are only offered while the controller is busy.
   a_valid_busy : assert property (@(posedge clk) disable iff (rst)
      out_valid |-> busy);

endmodule : gray_sweep_chk

// File: rtl/gray_sweep_ctrl.sv
// Gray-code sweep sequencer. Walks a binary index from a latched start
// value to a latched end value (up or down, modulo 2^WIDTH) and offers
// each binary/Gray pair on a valid/ready stream under host control.
module gray_sweep_ctrl
   import gray_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] end_val,
   input  logic             dir,
   input  logic             pause,
   input  logic             abort,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] binary,
   output logic [WIDTH-1:0] gray,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   state_t           state_r;
   logic [WIDTH-1:0] end_r;
   logic             dir_r;
   logic [WIDTH-1:0] step_s;
   logic [WIDTH-1:0] enc_in_s;
   logic [WIDTH-1:0] enc_gray_s;
   logic             transfer_s;
   logic             last_s;

   // Next index in the latched direction; natural overflow gives the wrap.
   always_comb begin
      step_s = binary;
      if (dir_r == DIR_UP) begin
         step_s = binary + ONE;
      end else begin
         step_s = binary - ONE;
      end
   end

   // One encoder serves both the start load (in IDLE) and every step.
   always_comb begin
      enc_in_s = step_s;
      if (state_r == IDLE) begin
         enc_in_s = start_val;
      end else begin
         enc_in_s = step_s;
      end
   end

   // Handshake and end-of-sweep detection for the word currently offered.
   always_comb begin
      transfer_s = out_valid & out_ready;
      last_s     = (binary == end_r);
   end

   gray_encode #(
      .WIDTH (WIDTH)
   ) u_encode (
      .bin  (enc_in_s),
      .gray (enc_gray_s)
   );

   // Sweep FSM; every output is a register so nothing is combinational
   // from inputs to outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         end_r     <= ZERO;
         dir_r     <= DIR_UP;
         binary    <= ZERO;
         gray      <= ZERO;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  end_r     <= end_val;
                  dir_r     <= dir;
                  binary    <= start_val;
                  gray      <= enc_gray_s;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= EMIT;
               end else begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            EMIT: begin
               if (abort) begin
                  // Abort outranks any transfer or pause in the same cycle.
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end else if (transfer_s) begin
                  if (last_s) begin
                     // Final word taken: keep it visible, report completion.
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     binary <= step_s;
                     gray   <= enc_gray_s;
                     if (pause) begin
                        out_valid <= 1'b0;
                        state_r   <= PAUSE;
                     end else begin
                        out_valid <= 1'b1;
                        state_r   <= EMIT;
                     end
                  end
               end else begin
                  // No transfer: word and valid hold regardless of pause.
                  state_r <= EMIT;
               end
            end
            PAUSE: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end else if (!pause) begin
                  out_valid <= 1'b1;
                  state_r   <= EMIT;
               end else begin
                  out_valid <= 1'b0;
                  state_r   <= PAUSE;
               end
            end
            DONE: begin
               // Single-cycle completion pulse; start is ignored here.
               done      <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   gray_sweep_chk #(
      .WIDTH (WIDTH)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .abort     (abort),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .binary    (binary),
      .gray      (gray),
      .busy      (busy),
      .done      (done)
   );

endmodule : gray_sweep_ctrl
